// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID decoupling FIFO of the pipelined RISC-V core.
// Buffers fetched (PC, instruction) pairs in a small circular FIFO and
// presents the oldest entry to decode. A flush discards every entry.
// Optional statistics counters are compiled in with `define IFQ_STATS_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high and flush is low. if_ready depends on the occupancy count only,
// so there is no combinational path from id_ready to if_ready. The head
// entry is held stable while id_valid=1 and id_ready=0.
module if_id_queue #(
  parameter int              XLEN      = 64,
  parameter int              ILEN      = 32,
  parameter int              DEPTH     = 2,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h00000013)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [ILEN-1:0] if_instr,
  output logic            if_ready,
  input  logic            flush,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc_plus4
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flushed_entries
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Occupancy condition; the only "state machine" of this block, derived
  // from count and kept as a named signal so checkers can bind to it.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_t;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  occ_t            occ;
  logic            push;
  logic            pop;

  // Classify occupancy from the count.
  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0)
      occ = OCC_EMPTY;
    else if (count == CW'(DEPTH))
      occ = OCC_FULL;
  end

  assign if_ready = (occ != OCC_FULL);
  assign id_valid = (occ != OCC_EMPTY);
  assign push     = if_valid & if_ready & ~flush;
  assign pop      = id_valid & id_ready & ~flush;

  // Pointer and count update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= if_pc;
      instr_mem[wr_ptr] <= if_instr;
    end
  end

  // Head presentation: NOP with PC 0 when empty, no same-cycle bypass.
  always_comb begin
    id_pc    = '0;
    id_instr = NOP_INSTR;
    if (id_valid) begin
      id_pc    = pc_mem[rd_ptr];
      id_instr = instr_mem[rd_ptr];
    end
  end

  assign id_pc_plus4 = id_pc + XLEN'(4);

`ifdef IFQ_STATS_EN
  logic [32:0] flush_sum;

  // Saturating accumulation of entries discarded by a flush.
  always_comb begin
    flush_sum = {1'b0, flushed_entries} + 33'(count);
  end

  // Stall counter: cycles where fetch offers an entry but the queue is full.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (if_valid && !if_ready && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end

  // Flushed-entry counter: adds the pre-flush occupancy, saturating.
  always_ff @(posedge clk) begin
    if (reset)
      flushed_entries <= '0;
    else if (flush)
      flushed_entries <= flush_sum[32] ? '1 : flush_sum[31:0];
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed bench for if_id_queue with a queue-based model.
// Inputs change and outputs are sampled at the falling clock edge.
module tb_if_id_queue;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 2;
  localparam logic [ILEN-1:0] NOP = 32'h00000013;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            if_ready;
  logic            flush;
  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc_plus4;
`ifdef IFQ_STATS_EN
  logic [31:0]     stall_cycles;
  logic [31:0]     flushed_entries;
  int              exp_stall   = 0;
  int              exp_flushed = 0;
`endif

  int checks = 0;
  int errors = 0;

  // Expected queue: {pc, instr} of every entry the model believes is stored.
  logic [XLEN+ILEN-1:0] exp_q[$];
  logic [XLEN-1:0]      got_q[$];

  // Clock and reset block.
  always #5 clk = ~clk;

  if_id_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .reset(reset),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instr(if_instr),
    .if_ready(if_ready),
    .flush(flush),
    .id_ready(id_ready),
    .id_valid(id_valid),
    .id_pc(id_pc),
    .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4)
`ifdef IFQ_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flushed_entries(flushed_entries)
`endif
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all DUT outputs against the model head.
  task automatic check_outputs(input string tag);
    logic [XLEN-1:0] e_pc;
    logic [ILEN-1:0] e_instr;
    e_pc    = '0;
    e_instr = NOP;
    if (exp_q.size() != 0) begin
      e_pc    = exp_q[0][XLEN+ILEN-1:ILEN];
      e_instr = exp_q[0][ILEN-1:0];
    end
    chk({tag, ".id_valid"}, XLEN'(id_valid), XLEN'(exp_q.size() != 0));
    chk({tag, ".if_ready"}, XLEN'(if_ready), XLEN'(exp_q.size() != DEPTH));
    chk({tag, ".id_pc"}, id_pc, e_pc);
    chk({tag, ".id_instr"}, XLEN'(id_instr), XLEN'(e_instr));
    chk({tag, ".id_pc_plus4"}, id_pc_plus4, e_pc + XLEN'(4));
  endtask

  // Driver: apply inputs for one cycle, check outputs, advance the model.
  task automatic step(input string tag, input logic v, input logic [XLEN-1:0] pc,
                      input logic [ILEN-1:0] instr, input logic rdy, input logic fl);
    logic do_push;
    logic do_pop;
    if_valid = v;
    if_pc    = pc;
    if_instr = instr;
    id_ready = rdy;
    flush    = fl;
    #1;
    check_outputs(tag);
    if (id_valid && rdy && !fl)
      got_q.push_back(id_pc);
    do_push = v && (exp_q.size() != DEPTH) && !fl;
    do_pop  = (exp_q.size() != 0) && rdy && !fl;
`ifdef IFQ_STATS_EN
    if (v && exp_q.size() == DEPTH) exp_stall++;
    if (fl) exp_flushed += exp_q.size();
`endif
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, instr});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_valid = 1'b0; if_pc = '0; if_instr = '0; id_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [ILEN-1:0] r;
    int              sent;
    int              cyc;
    logic [XLEN-1:0] pc;

    do_reset();
    // Reset then idle
    step("reset_idle", 0, '0, '0, 0, 0);

    // Single pass-through
    step("pass_push", 1, 64'h1000, 32'h00500093, 1, 0);
    step("pass_head", 0, '0, '0, 1, 0);
    step("pass_empty", 0, '0, '0, 1, 0);

    // Fill and stall, then drain in order
    step("fill0", 1, 64'h1000, 32'h00100093, 0, 0);
    step("fill1", 1, 64'h1004, 32'h00200093, 0, 0);
    for (int i = 0; i < 3; i++) step("stall", 1, 64'h1008, 32'h00300093, 0, 0);
    step("drain0", 1, 64'h1008, 32'h00300093, 1, 0);
    step("drain1", 1, 64'h1008, 32'h00300093, 1, 0);
    step("drain2", 0, '0, '0, 1, 0);
    step("drained", 0, '0, '0, 1, 0);

    // Simultaneous push/pop at count=1
    step("sim_head", 1, 64'h2000, 32'h00000093, 0, 0);
    step("sim_pp", 1, 64'h2004, 32'h00100113, 1, 0);
    step("sim_new", 0, '0, '0, 0, 0);
    step("sim_pop", 0, '0, '0, 1, 0);

    // Flush priority over push and pop
    step("fl_fill0", 1, 64'h2100, 32'h11111111, 0, 0);
    step("fl_fill1", 1, 64'h2104, 32'h22222222, 0, 0);
    step("fl_cycle", 1, 64'h2108, 32'h33333333, 1, 1);
    step("fl_after", 1, 64'h3000, 32'h44444444, 0, 0);
    step("fl_head", 0, '0, '0, 1, 0);

    // pc_plus4 wraps modulo 2^XLEN
    step("wrap_push", 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h55555555, 0, 0);
    step("wrap_pop", 0, '0, '0, 1, 0);

    // Stream 10 instructions with alternating id_ready
    got_q.delete();
    sent = 0;
    cyc  = 0;
    pc   = 64'h4000;
    while ((sent < 10 || exp_q.size() != 0) && cyc < 100) begin
      r = $urandom();
      if (sent < 10 && exp_q.size() != DEPTH) begin
        step("stream", 1, pc, r, cyc[0], 0);
        pc += 4;
        sent++;
      end else begin
        step("stream", sent < 10, pc, r, cyc[0], 0);
      end
      cyc++;
    end
    chk("stream_timeout", XLEN'(cyc < 100), XLEN'(1));
    chk("stream_count", XLEN'(got_q.size()), XLEN'(10));
    for (int k = 0; k < 10 && k < got_q.size(); k++)
      chk("stream_order", got_q[k], 64'h4000 + XLEN'(4 * k));

    // Flush at count=2 to exercise flushed_entries
    step("st_fill0", 1, 64'h5000, 32'h0, 0, 0);
    step("st_fill1", 1, 64'h5004, 32'h0, 0, 0);
    step("st_flush", 0, '0, '0, 0, 1);
    step("st_after", 0, '0, '0, 0, 0);
`ifdef IFQ_STATS_EN
    chk("stall_cycles", XLEN'(stall_cycles), XLEN'(exp_stall));
    chk("flushed_entries", XLEN'(flushed_entries), XLEN'(exp_flushed));
`endif

    // Reset mid-operation loses everything
    step("mr_fill", 1, 64'h6000, 32'h0, 0, 0);
    do_reset();
    step("mr_idle", 0, '0, '0, 0, 0);
`ifdef IFQ_STATS_EN
    chk("stall_clr", XLEN'(stall_cycles), XLEN'(0));
    chk("flushed_clr", XLEN'(flushed_entries), XLEN'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
